fifo_packer: RTL and testbench
==============================

Name: fifo_packer

Overview:
- Downstream consumer of the 4-deep nibble fifo.
- Drives the fifo's deque/dequed handshake and collects successive deque_data words into lanes of a wide output word.
- Presents the packed word on a valid/ready interface to the next stage.
- A flush input forces out a partially filled word, so stragglers are not stranded at end of stream.

Parameters:
DATA_WIDTH, 4, width of one fifo word (one lane)
LANES, 4, number of fifo words packed per output word (>=2)
CNT_WIDTH, 3, width of out_count; must hold value LANES

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
is_empty  in  1  from fifo: no data available
deque  out  1  to fifo: request one word this cycle
dequed  in  1  from fifo: deque_data valid this cycle (response to deque of previous cycle)
deque_data  in  DATA_WIDTH  from fifo: dequeued word
flush  in  1  single-cycle pulse: emit partial word
out_valid  out  1  packed word available
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  DATA_WIDTH*LANES  packed word, lane 0 = bits [DATA_WIDTH-1:0] = oldest word
out_count  out  CNT_WIDTH  number of valid lanes in out_data (1..LANES when out_valid)
protocol_err  out  1  sticky: dequed seen with no request outstanding

Behaviour:
- Reset values: deque=0, out_valid=0, out_data=0, out_count=0, protocol_err=0. Internal state is cleared: lane count=0, inflight=0, flush_pending=0.
- The fifo shares the same reset, so no response is owed after reset. dequed is ignored while reset is high.
- States:
  - FILL: out_valid=0.
  - EMIT: out_valid=1. out_data and out_count are held stable until the transfer.
- deque (combinational) = FILL && !is_empty && (count + inflight < LANES) && !flush_pending.
  - Back-to-back deques are permitted, at most one outstanding.
  - inflight is set on deque and cleared on dequed. A simultaneous new deque keeps it at 1.
- On dequed with inflight=1:
  - deque_data is written into lane[count]; count increments.
  - Unwritten lanes of out_data read 0.
- On dequed with inflight=0: data is discarded and protocol_err is set until reset.
- FILL->EMIT conditions:
  - count reaches LANES (registered on the dequed edge), so out_valid rises the cycle after the final dequed. Best-case latency from the first deque to out_valid is LANES+1 cycles.
  - Or flush_pending && inflight=0 && count>0.
- flush sets flush_pending, including when it arrives in EMIT or mid-fill.
  - While flush_pending, no new deque is issued; an outstanding dequed still completes into its lane.
  - With flush_pending && inflight=0 && count=0, flush_pending clears with no output (flush of empty is a no-op).
  - After an EMIT caused by flush, flush_pending clears on the transfer.
- EMIT->FILL on out_valid && out_ready:
  - count=0; out_data and out_count clear to 0 on that edge.
  - deque may assert on the next cycle. No deque is issued in the transfer cycle itself.
- out_valid never drops without a transfer. out_data is stable while out_valid && !out_ready.
- A full word (count=LANES) reports out_count=LANES.
- is_empty high stalls filling indefinitely. The block never deques when is_empty=1.
- Asserting reset mid-fill or mid-EMIT discards all partial data. Outputs go to their reset values asynchronously.

Test Plan:
- Fifo holds 1,2,3,4, out_ready=1 -> deque for 4 consecutive cycles; out_valid one cycle after the 4th dequed with out_data=16'h4321, out_count=4.
- Fifo holds 5,6 then empty; flush pulse -> out_data=16'h0065, out_count=2; deque stays 0 while is_empty.
- Full word 16'hA987 with out_ready=0 for 5 cycles -> out_valid held, data stable, deque=0; out_ready=1 -> transfer, next deque on following cycle.
- flush in same cycle as outstanding deque (1 word already in lane 0, second returning 0xB) -> out_data=16'h00B?, where lane0 is the earlier word, out_count=2, no further deque until the transfer.
- flush with count=0, inflight=0 -> no out_valid, flush_pending clears next cycle; dequed pulse with no deque -> protocol_err=1 and stays 1 until reset.
- Reset asserted with 3 lanes filled -> out_valid=0, out_count=0 immediately; after release, 4 new words pack cleanly with no stale lanes.

Source files
------------

// File: rtl/fifo_packer.sv
// fifo_packer: drains a word fifo via deque/dequed and packs LANES words into one valid/ready output word.
module fifo_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int LANES = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          is_empty,
  output logic                          deque,
  input  logic                          dequed,
  input  logic [DATA_WIDTH-1:0]         deque_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH*LANES-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]          out_count,
  output logic                          protocol_err
);
  typedef enum logic {FILL, EMIT} state_t;
  localparam logic [CNT_WIDTH:0] FULL = (CNT_WIDTH+1)'(LANES);
  state_t state;
  logic inflight, flush_pending, take;
  logic [CNT_WIDTH:0] committed, next_cnt;
  // out_count doubles as the lane fill pointer
  assign committed = {1'b0, out_count} + {{CNT_WIDTH{1'b0}}, inflight};
  assign next_cnt = {1'b0, out_count} + 1'b1;
  assign take = dequed && inflight;
  assign out_valid = state == EMIT;
  assign deque = !reset && state == FILL && !is_empty && committed < FULL && !flush_pending;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FILL;
      inflight <= 1'b0;
      flush_pending <= 1'b0;
      out_data <= '0;
      out_count <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (dequed && !inflight) protocol_err <= 1'b1;
      inflight <= deque || (inflight && !dequed);
      if (state == FILL) begin
        for (int i = 0; i < LANES; i++)
          if (take && out_count == CNT_WIDTH'(i)) out_data[i*DATA_WIDTH +: DATA_WIDTH] <= deque_data;
        if (take) out_count <= out_count + 1'b1;
        if ((take && next_cnt == FULL) || (flush_pending && !inflight && out_count != '0)) state <= EMIT;
        flush_pending <= flush || (flush_pending && (inflight || out_count != '0));
      end else if (out_ready) begin
        state <= FILL;
        out_data <= '0;
        out_count <= '0;
        flush_pending <= flush;
      end else if (flush) flush_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: directed vector table plus hand sequences against a one-cycle-latency fifo model.
module tb_fifo_packer;
  logic clock = 1'b0, reset, is_empty, deque, dequed, flush, out_valid, out_ready, protocol_err;
  logic [3:0] deque_data;
  logic [15:0] out_data;
  logic [2:0] out_count;
  logic req = 1'b0, manual;
  logic [3:0] q[$];
  int errors = 0, checks = 0;
  typedef struct {
    int n;
    logic [15:0] w;
    bit fl;
    logic [15:0] d;
    logic [2:0] c;
  } vec_t;
  vec_t v[6];

  fifo_packer #(.DATA_WIDTH(4), .LANES(4), .CNT_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .is_empty(is_empty), .deque(deque), .dequed(dequed),
    .deque_data(deque_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    req = deque;
    if (deque && is_empty) begin
      errors++;
      $display("FAIL deque_while_empty: deque=1 with is_empty=1 at %0t", $time);
    end
  end

  always @(posedge clock) begin
    #1;
    if (reset) q.delete();
    if (!manual) begin
      dequed = req && !reset;
      if (dequed && q.size() > 0) deque_data = q.pop_front();
      is_empty = q.size() == 0;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid();
    int c = 0;
    while (!out_valid && c < 50) begin @(negedge clock); c++; end
    chk("valid_timeout", out_valid, 1);
  endtask

  task automatic wait_deque();
    int c = 0;
    while (!deque && c < 50) begin @(negedge clock); c++; end
    chk("deque_timeout", deque, 1);
  endtask

  task automatic wait_count(int n);
    int c = 0;
    while (out_count != 3'(n) && c < 50) begin @(negedge clock); c++; end
    chk("count_timeout", out_count, n);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic transfer();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("xfer_valid", out_valid, 0);
    chk("xfer_data", out_data, 0);
    chk("xfer_count", out_count, 0);
  endtask

  initial begin
    int cyc, nd;
    v[0] = '{4, 16'h4321, 1'b0, 16'h4321, 3'd4};
    v[1] = '{2, 16'h0065, 1'b1, 16'h0065, 3'd2};
    v[2] = '{4, 16'hA987, 1'b0, 16'hA987, 3'd4};
    v[3] = '{1, 16'h000F, 1'b1, 16'h000F, 3'd1};
    v[4] = '{3, 16'h0EDC, 1'b1, 16'h0EDC, 3'd3};
    v[5] = '{4, 16'hF0F0, 1'b0, 16'hF0F0, 3'd4};
    reset = 1'b1; out_ready = 1'b0; flush = 1'b0; manual = 1'b0;
    dequed = 1'b0; deque_data = '0; is_empty = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_deque", deque, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_perr", protocol_err, 0);
    reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < v[k].n; i++) q.push_back(v[k].w[i*4 +: 4]);
      if (v[k].fl) begin
        wait_count(v[k].n);
        pulse_flush();
      end else begin
        wait_deque();
        cyc = 0; nd = 0;
        while (!out_valid && cyc < 50) begin nd += int'(deque); @(negedge clock); cyc++; end
        chk("latency", cyc, 5);
        chk("deque_cycles", nd, 4);
      end
      wait_valid();
      chk("vec_data", out_data, v[k].d);
      chk("vec_count", out_count, v[k].c);
      @(negedge clock);
      chk("vec_hold_valid", out_valid, 1);
      chk("vec_hold_data", out_data, v[k].d);
      transfer();
    end
    // backpressure on a full word with data waiting in the fifo
    q.push_back(4'h7); q.push_back(4'h8); q.push_back(4'h9); q.push_back(4'hA);
    wait_valid();
    q.push_back(4'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 16'hA987);
      chk("bp_deque", deque, 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_deque", deque, 1);
    repeat (2) @(negedge clock);
    chk("bp_lane0_count", out_count, 1);
    chk("bp_lane0_data", out_data, 16'h0001);
    // flush while the second word is still in flight
    q.push_back(4'hB);
    wait_deque();
    @(negedge clock);
    flush = 1'b1;
    q.push_back(4'hC);
    @(negedge clock);
    flush = 1'b0;
    chk("fl_inflight_deque", deque, 0);
    wait_valid();
    chk("fl_inflight_data", out_data, 16'h00B1);
    chk("fl_inflight_count", out_count, 2);
    chk("fl_inflight_deque2", deque, 0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("fl_next_deque", deque, 1);
    wait_count(1);
    pulse_flush();
    wait_valid();
    chk("fl_c_data", out_data, 16'h000C);
    chk("fl_c_count", out_count, 1);
    transfer();
    // flush of an empty packer is a no-op
    pulse_flush();
    for (int i = 0; i < 3; i++) begin
      chk("fl_empty_valid", out_valid, 0);
      @(negedge clock);
    end
    q.push_back(4'h5);
    wait_deque();
    // reset mid-fill drops partial lanes
    q.push_back(4'h6); q.push_back(4'h7);
    wait_count(3);
    chk("mid_valid", out_valid, 0);
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", out_count, 0);
    chk("arst_data", out_data, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    q.push_back(4'h1); q.push_back(4'h2); q.push_back(4'h3); q.push_back(4'h4);
    wait_valid();
    chk("post_rst_data", out_data, 16'h4321);
    chk("post_rst_count", out_count, 4);
    transfer();
    // unsolicited dequed
    manual = 1'b1;
    @(negedge clock);
    dequed = 1'b1;
    deque_data = 4'h9;
    @(negedge clock);
    dequed = 1'b0;
    chk("perr_set", protocol_err, 1);
    chk("perr_discard", out_count, 0);
    repeat (3) @(negedge clock);
    chk("perr_sticky", protocol_err, 1);
    manual = 1'b0;
    reset = 1'b1;
    #1;
    chk("perr_clear", protocol_err, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
